// File: rtl/hpdmc_pkg.sv
// Shared definitions for the hpdmc_ddr16 write path: sequencer states,
// burst lengths and the DQS drive pattern used in each state.
package hpdmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATENCY   = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_BURST     = 3'd3,
    ST_POSTAMBLE = 3'd4
  } wr_state_t;

  // Sys-side beats per burst: each beat carries two DRAM edges.
  localparam int BL4_BEATS = 2;
  localparam int BL8_BEATS = 4;

  typedef struct packed {
    logic oe;
    logic d0;
    logic d1;
  } dqs_pat_t;

  localparam dqs_pat_t DQS_OFF   = '{oe: 1'b0, d0: 1'b0, d1: 1'b0};
  localparam dqs_pat_t DQS_PRE   = '{oe: 1'b1, d0: 1'b0, d1: 1'b0};
  localparam dqs_pat_t DQS_BURST = '{oe: 1'b1, d0: 1'b1, d1: 1'b0};
  localparam dqs_pat_t DQS_POST  = '{oe: 1'b1, d0: 1'b0, d1: 1'b0};

  function automatic dqs_pat_t dqs_pattern(wr_state_t s);
    dqs_pat_t p;
    p = DQS_OFF;
    case (s)
      ST_PREAMBLE:  p = DQS_PRE;
      ST_BURST:     p = DQS_BURST;
      ST_POSTAMBLE: p = DQS_POST;
      default:      p = DQS_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hpdmc_wrseq.sv
// DDR write-burst sequencer: waits write latency, drives DQS preamble/burst/
// postamble and feeds data/mask pairs to the DQ/DM ODDR D0/D1 inputs.
module hpdmc_wrseq
  import hpdmc_pkg::*;
#(
  parameter int DQ_W = 16,
  parameter int DM_W = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_bl8,
  input  logic [1:0]        wr_latency,
  input  logic [2*DQ_W-1:0] wdata,
  input  logic [2*DM_W-1:0] wbe,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DQ_W-1:0]   dq_d0,
  output logic [DQ_W-1:0]   dq_d1,
  output logic [DM_W-1:0]   dm_d0,
  output logic [DM_W-1:0]   dm_d1,
  output logic [DM_W-1:0]   dqs_d0,
  output logic [DM_W-1:0]   dqs_d1,
  output logic              dq_oe,
  output logic              dqs_oe,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  wr_state_t  state_reg, state_next;
  logic [1:0] lat_cnt_reg, lat_cnt_next;
  logic [1:0] beat_cnt_reg, beat_cnt_next;
  logic       bl8_reg, bl8_next;
  logic       underrun_reg;
  logic [DQ_W-1:0] dq_d0_reg, dq_d1_reg;
  logic [DM_W-1:0] dm_d0_reg, dm_d1_reg;

  logic       accept;
  logic [1:0] last_beat;
  logic       fetch;
  dqs_pat_t   dqs_pat;

  assign last_beat = bl8_reg ? 2'(BL8_BEATS - 1) : 2'(BL4_BEATS - 1);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= ST_IDLE;
      lat_cnt_reg  <= 2'd0;
      beat_cnt_reg <= 2'd0;
      bl8_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lat_cnt_reg  <= lat_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      bl8_reg      <= bl8_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    bl8_next      = bl8_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          bl8_next      = cmd_bl8;
          lat_cnt_next  = wr_latency;
          beat_cnt_next = 2'd0;
          state_next    = (wr_latency != 2'd0) ? ST_LATENCY : ST_PREAMBLE;
        end
      end
      ST_LATENCY: begin
        if (lat_cnt_reg <= 2'd1) begin
          lat_cnt_next = 2'd0;
          state_next   = ST_PREAMBLE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 2'd1;
        end
      end
      ST_PREAMBLE: begin
        beat_cnt_next = 2'd0;
        state_next    = ST_BURST;
      end
      ST_BURST: begin
        if (beat_cnt_reg == last_beat) begin
          state_next = ST_POSTAMBLE;
        end else begin
          beat_cnt_next = beat_cnt_reg + 2'd1;
        end
      end
      ST_POSTAMBLE: state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Data is fetched one cycle ahead of the beat it drives, so the window
  // starts in PREAMBLE and ends one beat before the burst does.
  assign fetch = (state_reg == ST_PREAMBLE) ||
                 ((state_reg == ST_BURST) && (beat_cnt_reg != last_beat));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dq_d0_reg <= '0;
      dq_d1_reg <= '0;
      dm_d0_reg <= '1;
      dm_d1_reg <= '1;
    end else if (fetch) begin
      if (wdata_valid) begin
        dq_d0_reg <= wdata[2*DQ_W-1:DQ_W];
        dq_d1_reg <= wdata[DQ_W-1:0];
        dm_d0_reg <= ~wbe[2*DM_W-1:DM_W];
        dm_d1_reg <= ~wbe[DM_W-1:0];
      end else begin
        // DRAM timing cannot stall, so a missing beat is written fully masked.
        dq_d0_reg <= '0;
        dq_d1_reg <= '0;
        dm_d0_reg <= '1;
        dm_d1_reg <= '1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underrun_reg <= 1'b0;
    end else if (accept) begin
      underrun_reg <= 1'b0;
    end else if (fetch && !wdata_valid) begin
      underrun_reg <= 1'b1;
    end
  end

  assign dqs_pat     = dqs_pattern(state_reg);
  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_POSTAMBLE);
  assign dq_oe       = (state_reg == ST_BURST);
  assign dqs_oe      = dqs_pat.oe;
  assign dqs_d0      = {DM_W{dqs_pat.d0}};
  assign dqs_d1      = {DM_W{dqs_pat.d1}};
  assign wdata_ready = fetch;
  assign underrun    = underrun_reg;
  assign dq_d0       = dq_d0_reg;
  assign dq_d1       = dq_d1_reg;
  assign dm_d0       = dm_d0_reg;
  assign dm_d1       = dm_d1_reg;

endmodule

// File: tb/tb_hpdmc_wrseq.sv
// Directed bench for hpdmc_wrseq: per-cycle control timing model plus a
// beat scoreboard fed at fetch time and drained while dq_oe is high.
module tb_hpdmc_wrseq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_bl8;
  logic [1:0]  wr_latency;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        wdata_valid, wdata_ready;
  logic [15:0] dq_d0, dq_d1;
  logic [1:0]  dm_d0, dm_d1, dqs_d0, dqs_d1;
  logic        dq_oe, dqs_oe, busy, done, underrun;

  hpdmc_wrseq #(.DQ_W(16), .DM_W(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bl8(cmd_bl8),
    .wr_latency(wr_latency), .wdata(wdata), .wbe(wbe),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .dq_d0(dq_d0), .dq_d1(dq_d1), .dm_d0(dm_d0), .dm_d1(dm_d1),
    .dqs_d0(dqs_d0), .dqs_d1(dqs_d1), .dq_oe(dq_oe), .dqs_oe(dqs_oe),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        v;
  } stim_t;

  stim_t       stim_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] last_exp;
  int          errors = 0;
  int          checks = 0;
  logic        exp_underrun = 1'b0;
  logic        underrun_pending = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] be, input logic v);
    stim_t s;
    s.d = d; s.be = be; s.v = v;
    stim_q.push_back(s);
  endtask

  // One cycle: sample at the falling edge, score any beat on the bus, then
  // drive the next write beat if the sequencer is fetching.
  task automatic tick();
    stim_t s;
    logic [35:0] e;
    @(negedge sys_clk);
    exp_underrun = exp_underrun | underrun_pending;
    underrun_pending = 1'b0;
    if (dq_oe) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("beat", {28'd0, dq_d0, dq_d1, dm_d0, dm_d1}, {28'd0, e});
      end
    end
    chk("underrun", 64'(underrun), 64'(exp_underrun));
    if (wdata_ready) begin
      if (stim_q.size() != 0) s = stim_q.pop_front();
      else begin s.d = $urandom; s.be = 4'hF; s.v = 1'b0; end
      wdata = s.d; wbe = s.be; wdata_valid = s.v;
      if (s.v) exp_q.push_back({s.d[31:16], s.d[15:0], ~s.be[3:2], ~s.be[1:0]});
      else begin
        exp_q.push_back({16'h0000, 16'h0000, 2'b11, 2'b11});
        underrun_pending = 1'b1;
      end
      $display("beat fetched data=%h be=%h valid=%0d", s.d, s.be, s.v);
    end else begin
      // Junk with valid high outside the fetch window must be ignored.
      wdata = $urandom; wbe = 4'($urandom); wdata_valid = 1'b1;
    end
  endtask

  // Issue a command at the current cycle (T0) and check every cycle up to
  // the first IDLE cycle after the postamble against the burst timeline.
  task automatic run_burst(input logic bl8, input logic [1:0] lat, input logic hold);
    int n, l, beat;
    logic pre, bst, post, bsy;
    n = bl8 ? 4 : 2;
    l = int'(lat);
    cmd_valid = 1'b1; cmd_bl8 = bl8; wr_latency = lat;
    exp_underrun = 1'b0;
    for (int k = 1; k <= l + n + 3; k++) begin
      tick();
      if (k == 1 && !hold) begin
        cmd_valid = 1'b0; cmd_bl8 = ~bl8; wr_latency = ~lat;
      end
      pre  = (k == l + 1);
      bst  = (k >= l + 2) && (k <= l + n + 1);
      post = (k == l + n + 2);
      bsy  = (k <= l + n + 2);
      beat = k - l - 2;
      chk("ctl", {58'd0, bsy, !bsy, pre | bst | post, bst, pre | (bst && beat < n - 1), post},
                 {58'd0, busy, cmd_ready, dqs_oe, dq_oe, wdata_ready, done});
      chk("dqs", {60'd0, dqs_d0, dqs_d1}, {60'd0, (bst ? 2'b11 : 2'b00), 2'b00});
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("hold_dq", {28'd0, dq_d0, dq_d1, dm_d0, dm_d1}, {28'd0, last_exp});
    $display("burst bl8=%0d lat=%0d hold=%0d complete", bl8, lat, hold);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_bl8 = 1'b0; wr_latency = 2'd0;
    wdata = '0; wbe = '0; wdata_valid = 1'b0;
    last_exp = {16'h0, 16'h0, 2'b11, 2'b11};
    repeat (2) @(negedge sys_clk);
    chk("rst_ctl", {58'd0, busy, cmd_ready, dqs_oe, dq_oe, wdata_ready, done},
                   {58'd0, 6'b010000});
    chk("rst_data", {28'd0, dq_d0, dq_d1, dm_d0, dm_d1}, {28'd0, 32'h0, 4'hF});
    chk("rst_dqs_unr", {59'd0, dqs_d0, dqs_d1, underrun}, 64'd0);
    sys_rst_n = 1'b1;
    tick();

    // BL4, no extra latency
    push_beat(32'hAAAA5555, 4'hF, 1'b1);
    push_beat(32'h12345678, 4'hF, 1'b1);
    run_burst(1'b0, 2'd0, 1'b0);

    // BL8, latency 2
    push_beat(32'h01020304, 4'hF, 1'b1);
    push_beat(32'hA1B2C3D4, 4'hC, 1'b1);
    push_beat(32'hDEADBEEF, 4'h3, 1'b1);
    push_beat(32'hCAFEF00D, 4'hF, 1'b1);
    run_burst(1'b1, 2'd2, 1'b0);

    // Underrun on the second fetch; sticky while idle
    push_beat(32'h11112222, 4'hF, 1'b1);
    push_beat(32'h33334444, 4'hF, 1'b0);
    push_beat(32'h55556666, 4'hF, 1'b1);
    push_beat(32'h77778888, 4'hF, 1'b1);
    run_burst(1'b1, 2'd1, 1'b0);
    repeat (2) tick();

    // Partial masks, maximum latency (accept clears underrun)
    push_beat(32'h9ABCDEF0, 4'b1001, 1'b1);
    push_beat(32'h0F0F0F0F, 4'b0110, 1'b1);
    run_burst(1'b0, 2'd3, 1'b0);

    // cmd_valid held: second accept lands in the first IDLE cycle
    push_beat(32'h13572468, 4'hF, 1'b1);
    push_beat(32'h24681357, 4'hE, 1'b1);
    push_beat(32'hFEDCBA98, 4'h7, 1'b1);
    push_beat(32'h76543210, 4'hF, 1'b1);
    run_burst(1'b0, 2'd0, 1'b1);
    run_burst(1'b0, 2'd0, 1'b0);

    // Asynchronous reset during beat 1 of a BL8 burst
    for (int i = 0; i < 4; i++) push_beat(32'hC0DE0000 + i, 4'hF, 1'b1);
    cmd_valid = 1'b1; cmd_bl8 = 1'b1; wr_latency = 2'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_burst", {62'd0, dq_oe, busy}, {62'd0, 2'b11});
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {58'd0, busy, cmd_ready, dqs_oe, dq_oe, wdata_ready, done},
                         {58'd0, 6'b010000});
    chk("async_rst_dm", {60'd0, dm_d0, dm_d1}, {60'd0, 4'hF});
    $display("async reset applied mid-burst");
    exp_q.delete(); stim_q.delete();
    exp_underrun = 1'b0; underrun_pending = 1'b0;
    last_exp = {16'h0, 16'h0, 2'b11, 2'b11};
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {62'd0, cmd_ready, busy}, {62'd0, 2'b10});

    // Sanity burst after reset
    push_beat(32'h5A5AA5A5, 4'hF, 1'b1);
    push_beat(32'h3C3CC3C3, 4'h9, 1'b1);
    run_burst(1'b0, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_wrseq.md
Name: hpdmc_wrseq

Overview:
Write-burst sequencer for the hpdmc_ddr16 datapath. It takes one write command from the DRAM command scheduler and waits the programmed write latency. It then generates the DQS preamble, burst and postamble, and feeds data and mask to the dual-edge output register pairs (D0 = first edge, D1 = second edge). It owns DQ/DQS/DM output-enable timing and the write-data handshake. Sits between the scheduler/write FIFO and the ODDR pad wrappers.

Parameters:
DQ_W, 16, DRAM data width per edge; sys-side beat width is 2*DQ_W.
DM_W, 2, DRAM mask width per edge (DQ_W/8).

Ports:
sys_clk  in  1  system clock; ODDR C0 = sys_clk, C1 = inverted sys_clk at the parent.
sys_rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  write command request from scheduler.
cmd_ready  out  1  high only in IDLE.
cmd_bl8  in  1  sampled on accept; 1 = BL8 (4 beats), 0 = BL4 (2 beats).
wr_latency  in  2  sampled on accept; extra cycles before preamble (0..3).
wdata  in  2*DQ_W  beat data; [2*DQ_W-1:DQ_W] is the first edge.
wbe  in  2*DM_W  byte enables, 1 = write; upper half is the first edge.
wdata_valid  in  1  write data available.
wdata_ready  out  1  beat consumed this cycle.
dq_d0, dq_d1  out  DQ_W each  to DQ ODDR D0/D1.
dm_d0, dm_d1  out  DM_W each  to DM ODDR D0/D1; 1 = masked.
dqs_d0, dqs_d1  out  DM_W each  to DQS ODDR D0/D1.
dq_oe  out  1  DQ/DM tristate enable.
dqs_oe  out  1  DQS tristate enable.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse in POSTAMBLE.
underrun  out  1  sticky; cleared on the next command accept.

Behaviour:
- Reset (async, immediate, including mid-burst): state IDLE; dq_oe = dqs_oe = 0; dq_d* = 0; dm_d* = all-ones; dqs_d* = 0; busy = done = underrun = 0; wdata_ready = 0; cmd_ready = 1.
- Accept = cmd_valid & cmd_ready. Sample cmd_bl8 into N (2 or 4) and wr_latency into the latency counter. Clear underrun.
- States:
  - IDLE: on accept, go to LATENCY if wr_latency != 0, else PREAMBLE.
  - LATENCY: count down wr_latency cycles, then PREAMBLE.
  - PREAMBLE: 1 cycle, then BURST.
  - BURST: N cycles, beat counter 0..N-1; after beat N-1, go to POSTAMBLE.
  - POSTAMBLE: 1 cycle, then IDLE.
- Accept at T0 places the first BURST beat at T0 + wr_latency + 2.
- All control outputs (cmd_ready, busy, done, dq_oe, dqs_oe, dqs_d*, wdata_ready) are Moore outputs decoded from registered state. There is no input-to-output combinational path.
- DQS:
  - PREAMBLE: dqs_oe = 1, dqs_d0 = dqs_d1 = 0.
  - BURST: dqs_oe = 1, dqs_d0 = all-ones, dqs_d1 = 0.
  - POSTAMBLE: dqs_oe = 1, both 0.
  - Otherwise dqs_oe = 0.
- DQ/DM pipeline:
  - wdata_ready is high in PREAMBLE and in BURST beats 0..N-2, i.e. exactly N cycles.
  - At each clock edge where wdata_ready = 1, register: dq_d0 <= wdata high half, dq_d1 <= low half, dm_d0 <= ~wbe high half, dm_d1 <= ~wbe low half.
  - Registered data therefore appears during beats 0..N-1.
  - dq_oe = 1 only in BURST.
- Underrun: if wdata_ready & ~wdata_valid, register dq = 0 and dm = all-ones (beat masked) and set underrun. The burst never stalls, because DRAM timing is fixed.
- Outside BURST, dq_d* and dm_d* hold their last values (dq_oe = 0).
- cmd_valid while busy: ignored, not queued; cmd_ready = 0. No seamless back-to-back; minimum command spacing is wr_latency + N + 3 cycles.
- Changes on cmd_bl8 or wr_latency after accept have no effect on the current burst.

Decomposition:
- Shared package hpdmc_pkg:
  - state encoding (IDLE, LATENCY, PREAMBLE, BURST, POSTAMBLE);
  - BL4_BEATS = 2 and BL8_BEATS = 4;
  - DQS pattern constants per state.
- No sub-module: single FSM plus two small counters. ODDR pair instantiation stays in the parent PHY.

Test Plan:
- BL4, wr_latency = 0, data 32'hAAAA5555 then 32'h12345678, wbe = 4'hF. Accept at T0 -> PREAMBLE at T1; beats at T2, T3 with dq_d0/dq_d1 = AAAA/5555, then 1234/5678; dm = 0; done at T4; cmd_ready at T5.
- BL8, wr_latency = 2, four beats. Accept at T0 -> dqs_oe from T3 to T8; dq_oe T4..T7; wdata_ready T3..T6; dqs_d0 = 2'b11 only in T4..T7.
- Underrun: BL8 with wdata_valid low on the 2nd fetch -> beat 1 has dq = 0, dm_d0 = dm_d1 = 2'b11; underrun = 1 until the next accept; burst length unchanged.
- Partial mask: wbe = 4'b1001 -> dm_d0 = 2'b01, dm_d1 = 2'b10.
- cmd_valid held high through a BL4 burst -> the second accept occurs only in the cycle after POSTAMBLE (the first IDLE cycle); no output overlap.
- sys_rst_n asserted mid-BURST (beat 1 of BL8) -> dq_oe, dqs_oe, busy and wdata_ready drop asynchronously; dm = all-ones; after release, IDLE with cmd_ready = 1.
